// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-path widths, reset PC and the fetch queue entry layout.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h8000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_buffer.sv
// ifetch_buffer: in-order instruction fetch queue between program_counter/imem and decode,
// with stale-response dropping after a redirect.
module ifetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_curr,
  output logic            pc_en,
  input  logic            redirect,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            out_valid,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            out_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);
  fetch_entry_t  r_q [DEPTH];
  logic [PW-1:0] r_alloc, r_fill, r_head;
  logic [CW-1:0] r_used, r_drop_cnt, r_outst;
  logic          w_alloc, w_pop, w_keep;
  logic [CW:0]   w_credit;
  // Dropped-but-pending responses still occupy credits so the queue never overflows.
  assign w_credit       = {1'b0, r_used} + {1'b0, r_drop_cnt};
  assign imem_req_valid = !rst && !redirect && (w_credit < LIMIT);
  assign imem_req_addr  = pc_curr;
  assign w_alloc        = imem_req_valid && imem_req_ready;
  assign pc_en          = w_alloc;
  assign out_valid      = r_q[r_head].filled;
  assign out_instr      = r_q[r_head].instr;
  assign out_pc         = r_q[r_head].pc;
  assign w_pop          = out_valid && out_ready && !redirect;
  assign w_keep         = imem_rsp_valid && (r_drop_cnt == '0);
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
      r_alloc    <= '0;
      r_fill     <= '0;
      r_head     <= '0;
      r_used     <= '0;
      r_outst    <= '0;
      r_drop_cnt <= rst ? '0 : r_drop_cnt + r_outst - CW'(imem_rsp_valid);
    end else begin
      if (w_pop) begin
        r_q[r_head] <= '0;
        r_head      <= r_head + PW'(1);
      end
      if (w_alloc) begin
        r_q[r_alloc] <= '{pc: pc_curr, instr: '0, filled: 1'b0};
        r_alloc      <= r_alloc + PW'(1);
      end
      if (w_keep) begin
        r_q[r_fill].instr  <= imem_rsp_data;
        r_q[r_fill].filled <= 1'b1;
        r_fill             <= r_fill + PW'(1);
      end
      if (imem_rsp_valid && !w_keep) r_drop_cnt <= r_drop_cnt - CW'(1);
      r_used  <= r_used + CW'(w_alloc) - CW'(w_pop);
      r_outst <= r_outst + CW'(w_alloc) - CW'(w_keep);
    end
  end
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (r_drop_cnt != '0 || r_outst != '0));
endmodule

// File: tb/tb_ifetch_buffer.sv
// tb_ifetch_buffer: directed checks of ifetch_buffer against a fixed-latency memory and a PC model.
module tb_ifetch_buffer;
  import fetch_pkg::*;
  logic        clk = 0, rst = 1, redirect = 0, imem_req_ready = 1, imem_rsp_valid = 0, out_ready = 0;
  logic [31:0] pc_curr = RESET_PC, imem_rsp_data = 0;
  logic        pc_en, imem_req_valid, out_valid;
  logic [31:0] imem_req_addr, out_instr, out_pc;
  int          n_chk = 0, n_err = 0, hs_cnt = 0, pop_cnt = 0, lat = 2;
  logic [31:0] exp_pc = RESET_PC, tgt = 0;
  logic        sv [8];
  logic [31:0] sa [8];
  ifetch_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc_curr(pc_curr), .pc_en(pc_en), .redirect(redirect),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    logic hs, pop, r, rd;
    logic [31:0] a;
    @(negedge clk);
    hs = pc_en;
    a = imem_req_addr;
    r = rst;
    rd = redirect;
    pop = out_valid && out_ready && !redirect && !rst;
    if (pop) begin
      chk("pop_pc", out_pc, exp_pc);
      chk("pop_instr", out_instr, ins(exp_pc));
      exp_pc += 4;
      pop_cnt++;
    end
    if (hs) hs_cnt++;
    @(posedge clk);
    #1;
    if (r) begin
      pc_curr = RESET_PC;
      exp_pc = RESET_PC;
      for (int i = 0; i < 8; i++) sv[i] = 0;
    end else begin
      if (rd) begin
        pc_curr = tgt;
        exp_pc = tgt;
      end else if (hs) pc_curr += 4;
      for (int i = 0; i < 7; i++) begin
        sv[i] = sv[i+1];
        sa[i] = sa[i+1];
      end
      sv[7] = 0;
      if (hs) begin
        sv[lat-1] = 1;
        sa[lat-1] = a;
      end
    end
    imem_rsp_valid = sv[0];
    imem_rsp_data = sv[0] ? ins(sa[0]) : 32'h0;
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    tick();
    rst = 0;
    #1;
    hs_cnt = 0;
    pop_cnt = 0;
  endtask
  initial begin
    for (int i = 0; i < 8; i++) begin
      sv[i] = 0;
      sa[i] = 0;
    end
    tick();
    tick();
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    // free run, 2-cycle memory
    lat = 2;
    out_ready = 1;
    do_reset();
    chk("run_req_valid", imem_req_valid, 1);
    chk("run_req_addr", imem_req_addr, 32'h8000_0000);
    repeat (3) tick();
    chk("run_first_valid", out_valid, 1);
    chk("run_first_pc", out_pc, 32'h8000_0000);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("run_sustain", out_valid, 1);
    end
    chk("run_pops", pop_cnt, 12);
    // backpressure
    out_ready = 0;
    do_reset();
    repeat (10) tick();
    chk("bp_accepted", hs_cnt, 4);
    chk("bp_req_valid", imem_req_valid, 0);
    chk("bp_head_pc", out_pc, 32'h8000_0000);
    out_ready = 1;
    #1;
    chk("bp_pop_no_credit", imem_req_valid, 0);
    tick();
    chk("bp_req_resume", imem_req_valid, 1);
    chk("bp_next_head", out_pc, 32'h8000_0004);
    // redirect with 3 outstanding, 4-cycle memory
    lat = 4;
    do_reset();
    repeat (3) tick();
    chk("rd3_outstanding", hs_cnt, 3);
    tgt = 32'h8000_0100;
    redirect = 1;
    #1;
    chk("rd3_req_blocked", imem_req_valid, 0);
    tick();
    redirect = 0;
    #1;
    chk("rd3_drop_cnt", dut.r_drop_cnt, 3);
    chk("rd3_used", dut.r_used, 0);
    chk("rd3_req_valid", imem_req_valid, 1);
    chk("rd3_req_addr", imem_req_addr, 32'h8000_0100);
    repeat (20) tick();
    chk("rd3_new_pops", pop_cnt > 0, 1);
    // redirect coinciding with a response
    lat = 2;
    do_reset();
    tick();
    tick();
    tgt = 32'h8000_0200;
    redirect = 1;
    tick();
    redirect = 0;
    #1;
    chk("rdr_drop_cnt", dut.r_drop_cnt, 1);
    chk("rdr_used", dut.r_used, 0);
    repeat (12) tick();
    chk("rdr_new_pops", pop_cnt > 0, 1);
    // simultaneous alloc, fill and pop at used == 2
    lat = 1;
    do_reset();
    tick();
    tick();
    chk("sim_used", dut.r_used, 2);
    chk("sim_valid", out_valid, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sim_used_hold", dut.r_used, 2);
    end
    chk("sim_pops", pop_cnt, 6);
    // synchronous reset mid-stream
    out_ready = 0;
    tick();
    tick();
    rst = 1;
    tick();
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_req_valid", imem_req_valid, 0);
    chk("mrst_out_pc", out_pc, 0);
    chk("mrst_used", dut.r_used, 0);
    rst = 0;
    out_ready = 1;
    #1;
    chk("mrst_req_valid_rel", imem_req_valid, 1);
    chk("mrst_req_addr", imem_req_addr, 32'h8000_0000);
    pop_cnt = 0;
    repeat (5) tick();
    chk("mrst_pops", pop_cnt > 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
